// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;
  localparam logic [1:0] WB_WIDTH_WORD = 2'b10;
  localparam logic [31:0] INST_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer; flush beats push, push+pop legal even when full.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic push_ok, pop_ok;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign pop_ok  = pop_i & !empty_o;
  assign push_ok = push_i & (!full_o | pop_ok);
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Wishbone instruction fetch with buffered valid/ready output and redirect flush.
// FETCH_ALIGN_CHECK_EN: misaligned redirects trap into HALT with fault raised.
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_width_o,
  input  logic [31:0] mem_data_read_i,
  input  logic        mem_ack_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        fault_o
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_pc;
  logic misalign, full, empty, accept;
  fetch_entry_t head;
`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_pc   = redirect_pc_i;
  assign misalign = |redirect_pc_i[1:0];
`else
  assign tgt_pc   = redirect_pc_i & ~32'h3;
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = redirect_valid_i ? (misalign ? HALT : FETCH)
            : (state_q == IDLE ? FETCH : state_q);
  end
  always_comb begin
    mem_stb_o    = (state_q == FETCH) && !full;
    mem_cyc_o    = mem_stb_o;
    mem_we_o     = 1'b0;
    mem_addr_o   = pc_q;
    mem_width_o  = WB_WIDTH_WORD;
    inst_valid_o = !empty && !redirect_valid_i;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_o      = state_q == HALT;
`else
    fault_o      = 1'b0;
`endif
  end
  // A redirect in the same cycle as ack throws that word away.
  assign accept = mem_stb_o & mem_ack_i & !redirect_valid_i;
  assign pc_d   = redirect_valid_i ? tgt_pc : (accept ? pc_q + INST_STEP : pc_q);
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .nRst   (nRst),
    .push_i (accept),
    .pop_i  (inst_valid_o & inst_ready_i),
    .flush_i(redirect_valid_i),
    .din_i  ('{pc: pc_q, inst: mem_data_read_i}),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
  assign inst_o    = head.inst;
  assign inst_pc_o = head.pc;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. It sits directly upstream of the on-chip ROM/instruction memory and drives it as a Wishbone master, issuing aligned 32-bit reads at the program counter. Returned words are buffered in a small FIFO and handed to decode over a valid/ready handshake. Control-flow redirects from later stages flush the buffer and restart fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.
- clk  in  1  system clock, rising edge.
- nRst  in  1  asynchronous, active-low reset.
- mem_wb  WISHBONE_IF.master  -  instruction bus: drives cyc, stb, we, addr, width; samples data_read, ack.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- inst_valid  out  1  inst/inst_pc hold a valid word.
- inst_ready  in  1  decode accepts the word this cycle.
- inst  out  32  instruction word (byte at addr in [7:0]).
- inst_pc  out  32  address of inst.
- fault  out  1  misaligned redirect trap (FETCH_ALIGN_CHECK_EN only).

## Operation
- States: IDLE (in reset only), FETCH, HALT.
- After nRst deasserts, IDLE moves to FETCH on the next clk edge.
- In FETCH: cyc = stb = !fifo_full; we = 0; width = 2'b10 (word); addr = pc.
- Accept: ack & stb pushes {pc, data_read} into the FIFO, and pc <= pc + 4. The add is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0.
- ack is sampled only while stb is high. ack without stb is ignored.
- Pop: inst_valid & inst_ready removes the FIFO head. Push and pop in the same cycle are legal at any fill level, including full.
- Full: stb drops and pc holds. Fetch resumes the cycle after the count falls below FIFO_DEPTH.
- Redirect (redirect_valid = 1) has priority over everything else in that cycle:
  - FIFO is cleared and pc <= redirect_pc.
  - Any ack in that cycle is discarded.
  - inst_valid is forced to 0.
  - The next cycle fetches redirect_pc.
- HALT: cyc = stb = 0 and fault = 1. Leave only via an aligned redirect (back to FETCH) or reset.
- Reset mid-transfer: cyc/stb drop asynchronously. FIFO, pc and state reinitialise. The partial transfer is abandoned.

## Timing
- Reset values:
  - cyc = stb = we = 0; addr = RESET_PC; width = 2'b10.
  - inst_valid = 0; inst = 0; inst_pc = 0; fault = 0.
- The slave may ack combinationally in the same cycle as stb (zero-wait ROM) or after any number of wait cycles. Master holds addr and stb stable until ack.
- Latency: word accepted at edge N appears with inst_valid = 1 after edge N (registered FIFO output).
- First instruction: inst_valid rises two cycles after reset release when the slave has zero wait states.
- Throughput: one word per cycle sustained with zero-wait slave and inst_ready held at 1.
- inst/inst_pc stay stable while inst_valid & !inst_ready.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the FIFO, latches pc <= redirect_pc, and enters HALT with fault = 1.
  - inst_pc of the next aligned redirect is the restart point.
- FETCH_ALIGN_CHECK_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - HALT is unreachable and fault is tied 0.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, HALT}.
  - WB_WIDTH_WORD = 2'b10.
  - INST_STEP = 32'd4.
  - fetch_entry_t struct {pc[31:0], inst[31:0]}.
- Sub-module fetch_fifo (parameter DEPTH, entry type fetch_entry_t). Ports: push, pop, flush, full, empty, head. Flush wins over push in the same cycle.
- Top level contains the state machine, pc register and Wishbone drive only.

## Test plan
- Reset with RESET_PC = 0, zero-wait ROM holding 0x11,0x22,0x33,0x44 at 0..3 -> first inst = 32'h44332211, inst_pc = 0, two cycles after reset release; addr then steps 4, 8, ...
- inst_ready held 0 for 5 cycles -> exactly 2 words buffered, stb low while full, no words lost. Releasing ready yields pc 0, 4, 8 in order at one per cycle.
- Slave inserts 3 wait cycles before ack -> addr/stb stable throughout, one push per ack, no duplicate words.
- redirect_valid with redirect_pc = 32'h100 in the same cycle as ack -> ack data discarded, inst_valid = 0 that cycle, next addr = 32'h100, next inst_pc = 32'h100.
- Redirect to 32'hFFFF_FFFC -> fetches 32'hFFFF_FFFC, then addr wraps to 32'h0.
- FETCH_ALIGN_CHECK_EN: redirect to 32'h102 -> fault = 1, cyc = 0 until redirect to 32'h200, then fetch resumes at 32'h200 with fault = 0.
